// File: rtl/hc_core_scheduler.sv
// hc_core_scheduler
//
// Launches a job on a set of accelerator cores and waits for them to finish.
// A job is started by a one-cycle 'start' pulse. The cores selected by
// 'core_mask' receive a one-cycle 'core_start' pulse. The scheduler then
// collects their 'core_finish' indications. When every selected core has
// finished, it emits a one-cycle 'finish' pulse.
//
// Optional feature: define HC_SCHED_WATCHDOG_EN to build a watchdog. The
// watchdog ends a job after 'timeout_limit' RUN cycles and sets 'timed_out'.
// A limit of 0 disables it. Without the macro, 'timeout_limit' is ignored
// and 'timed_out' is tied low.
//
// Ports:
//   clk           - single clock
//   reset_n       - asynchronous active-low reset
//   start         - job-start pulse (honoured only in IDLE)
//   core_mask     - cores to run, sampled with an accepted start
//   timeout_limit - watchdog limit in cycles, sampled with an accepted start
//   core_finish   - per-core finish pulses or levels
//   core_start    - per-core one-cycle start pulses
//   finish        - one-cycle job-complete pulse
//   busy          - high from LAUNCH through DONE
//   done_mask     - cores that finished in the current or last job
//   timed_out     - last job was ended by the watchdog
//   run_cycles    - LAUNCH+RUN cycle count of the current or last job (saturating)

module hc_core_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int CYCLE_W   = 32,
  parameter int TIMEOUT_W = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [NUM_CORES-1:0] core_mask,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  input  logic [NUM_CORES-1:0] core_finish,
  output logic [NUM_CORES-1:0] core_start,
  output logic                 finish,
  output logic                 busy,
  output logic [NUM_CORES-1:0] done_mask,
  output logic                 timed_out,
  output logic [CYCLE_W-1:0]   run_cycles
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [NUM_CORES-1:0] mask_q;
  logic                 accept;
  logic                 complete;
  logic                 wd_expire;
  logic                 timeout_hit;

  // All selected cores have reported. A zero mask never reaches RUN, so an
  // empty mask cannot complete a job by accident.
  assign complete = (done_mask == mask_q);

`ifdef HC_SCHED_WATCHDOG_EN
  logic [TIMEOUT_W-1:0] limit_q;
  logic [TIMEOUT_W-1:0] wd_count;
  logic                 timed_out_q;

  // wd_count holds the number of RUN cycles already completed. The current
  // cycle is the last one allowed when wd_count+1 reaches the limit. The
  // compare uses one extra bit so that an all-ones limit cannot wrap.
  assign timeout_hit = (limit_q != '0) &&
                       (({1'b0, wd_count} + 1'b1) >= {1'b0, limit_q});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      limit_q     <= '0;
      wd_count    <= '0;
      timed_out_q <= 1'b0;
    end else begin
      if (accept) begin
        limit_q     <= timeout_limit;
        timed_out_q <= 1'b0;
      end else if (wd_expire) begin
        timed_out_q <= 1'b1;
      end
      if (state == LAUNCH) begin
        wd_count <= '0;
      end else if (state == RUN) begin
        wd_count <= wd_count + 1'b1;
      end
    end
  end

  assign timed_out = timed_out_q;
`else
  logic unused_timeout_limit;

  assign unused_timeout_limit = ^timeout_limit;
  assign timeout_hit          = 1'b0;
  assign timed_out            = 1'b0;
`endif

  // Next-state logic. Completion takes priority over the watchdog, so a job
  // that finishes in the same cycle as the timeout counts as a normal finish.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    wd_expire  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = (core_mask != '0) ? LAUNCH : DONE;
        end
      end
      LAUNCH: state_next = RUN;
      RUN: begin
        if (complete) begin
          state_next = DONE;
        end else if (timeout_hit) begin
          wd_expire  = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Job bookkeeping. An accepted start clears all per-job results.
  // Finishes are collected during LAUNCH as well as RUN, so a core that
  // answers immediately is not missed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= '0;
      done_mask  <= '0;
      run_cycles <= '0;
    end else begin
      if (accept) begin
        mask_q     <= core_mask;
        done_mask  <= '0;
        run_cycles <= '0;
      end else if ((state == LAUNCH) || (state == RUN)) begin
        done_mask <= done_mask | (core_finish & mask_q);
        if (run_cycles != '1) begin
          run_cycles <= run_cycles + 1'b1;
        end
      end
    end
  end

  assign core_start = (state == LAUNCH) ? mask_q : '0;
  assign finish     = (state == DONE);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_hc_core_scheduler.sv
// Directed testbench for hc_core_scheduler (NUM_CORES=4).
//
// A second instance is built with a 3-bit cycle counter so that
// run_cycles saturation is observable.
// When HC_SCHED_WATCHDOG_EN is defined, the watchdog jobs are run as well.

module tb_hc_core_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  core_mask = '0;
  logic [23:0] timeout_limit = '0;
  logic [3:0]  core_finish = '0;

  logic [3:0]  core_start, done_mask;
  logic        finish, busy, timed_out;
  logic [31:0] run_cycles;

  logic [3:0]  core_start_s, done_mask_s;
  logic        finish_s, busy_s, timed_out_s;
  logic [2:0]  run_cycles_s;

  int errors = 0;
  int checks = 0;

  hc_core_scheduler #(.NUM_CORES(4), .CYCLE_W(32), .TIMEOUT_W(24)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .core_mask(core_mask),
    .timeout_limit(timeout_limit), .core_finish(core_finish),
    .core_start(core_start), .finish(finish), .busy(busy),
    .done_mask(done_mask), .timed_out(timed_out), .run_cycles(run_cycles)
  );

  hc_core_scheduler #(.NUM_CORES(4), .CYCLE_W(3), .TIMEOUT_W(24)) dut_sat (
    .clk(clk), .reset_n(reset_n), .start(start), .core_mask(core_mask),
    .timeout_limit(timeout_limit), .core_finish(core_finish),
    .core_start(core_start_s), .finish(finish_s), .busy(busy_s),
    .done_mask(done_mask_s), .timed_out(timed_out_s), .run_cycles(run_cycles_s)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts one job and steps through it cycle by cycle.
  // Cycle k is observed on the k-th falling edge after the start pulse.
  // Up to three finish events (cycle, vector) can be scheduled.
  // strayAt, if nonzero, adds an extra start pulse with an all-ones mask.
  // finAt is the cycle in which finish is expected.
  task automatic runJob(input string tag, input logic [3:0] mask, input logic [23:0] limit,
                        input int c1, input logic [3:0] v1,
                        input int c2, input logic [3:0] v2,
                        input int c3, input logic [3:0] v3,
                        input int strayAt, input int finAt,
                        input logic [3:0] expDone, input int expRun, input logic expTo);
    int satRun;
    satRun = (expRun > 7) ? 7 : expRun;
    @(negedge clk);
    start = 1'b1;
    core_mask = mask;
    timeout_limit = limit;
    core_finish = '0;
    for (int k = 1; k <= finAt + 1; k++) begin
      @(negedge clk);
      start = (k == strayAt);
      core_mask = (k == strayAt) ? 4'b1111 : mask;
      core_finish = ((k == c1) ? v1 : 4'b0) | ((k == c2) ? v2 : 4'b0) |
                    ((k == c3) ? v3 : 4'b0);
      checkOutput({tag, " core_start"}, {28'd0, core_start}, (k == 1) ? {28'd0, mask} : 32'd0);
      checkOutput({tag, " finish"}, {31'd0, finish}, {31'd0, (k == finAt)});
      checkOutput({tag, " busy"}, {31'd0, busy}, {31'd0, (k <= finAt)});
      if (k == finAt) begin
        checkOutput({tag, " done_mask"}, {28'd0, done_mask}, {28'd0, expDone});
        checkOutput({tag, " run_cycles"}, run_cycles, expRun);
        checkOutput({tag, " run_cycles_sat"}, {29'd0, run_cycles_s}, satRun);
        checkOutput({tag, " timed_out"}, {31'd0, timed_out}, {31'd0, expTo});
      end
    end
    start = 1'b0;
    core_finish = '0;
  endtask

  initial begin
    // Reset state, before any clock edge has been honoured.
    #12;
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset finish", {31'd0, finish}, 32'd0);
    checkOutput("reset core_start", {28'd0, core_start}, 32'd0);
    checkOutput("reset done_mask", {28'd0, done_mask}, 32'd0);
    checkOutput("reset run_cycles", run_cycles, 32'd0);
    checkOutput("reset timed_out", {31'd0, timed_out}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Cores 1 and 3 finish at +5 and +9.
    runJob("sparse", 4'b1010, 24'd0, 5, 4'b0010, 9, 4'b1000, 0, 4'b0,
           0, 11, 4'b1010, 10, 1'b0);
    // All four cores finish together at +3.
    runJob("all", 4'b1111, 24'd0, 3, 4'b1111, 0, 4'b0, 0, 4'b0,
           0, 5, 4'b1111, 4, 1'b0);
    // Empty mask: straight to DONE with no core_start.
    runJob("empty", 4'b0000, 24'd0, 0, 4'b0, 0, 4'b0, 0, 4'b0,
           0, 1, 4'b0000, 0, 1'b0);
    // Finish during the LAUNCH cycle is captured.
    runJob("launchfin", 4'b0001, 24'd0, 1, 4'b0001, 0, 4'b0, 0, 4'b0,
           0, 3, 4'b0001, 2, 1'b0);
    // Stray start and unmasked finishes during RUN are ignored.
    runJob("stray", 4'b0011, 24'd0, 3, 4'b1100, 5, 4'b0001, 6, 4'b0010,
           3, 8, 4'b0011, 7, 1'b0);
`ifdef HC_SCHED_WATCHDOG_EN
    // Only core 0 finishes: the watchdog ends the job after 20 RUN cycles.
    runJob("watchdog", 4'b0011, 24'd20, 3, 4'b0001, 0, 4'b0, 0, 4'b0,
           0, 22, 4'b0001, 21, 1'b1);
    // Limit 0 disables the watchdog.
    runJob("limit0", 4'b0011, 24'd0, 3, 4'b0001, 35, 4'b0010, 0, 4'b0,
           0, 37, 4'b0011, 36, 1'b0);
`else
    // No watchdog in this build: the limit is ignored and the job waits for core 1.
    runJob("nowd", 4'b0011, 24'd20, 3, 4'b0001, 35, 4'b0010, 0, 4'b0,
           0, 37, 4'b0011, 36, 1'b0);
`endif

    // Reset in the middle of RUN abandons the job.
    @(negedge clk);
    start = 1'b1;
    core_mask = 4'b1111;
    timeout_limit = '0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset finish", {31'd0, finish}, 32'd0);
    checkOutput("midreset core_start", {28'd0, core_start}, 32'd0);
    checkOutput("midreset done_mask", {28'd0, done_mask}, 32'd0);
    checkOutput("midreset run_cycles", run_cycles, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    core_finish = 4'b1111;
    @(negedge clk);
    core_finish = '0;
    checkOutput("postreset done_mask", {28'd0, done_mask}, 32'd0);
    checkOutput("postreset busy", {31'd0, busy}, 32'd0);
    checkOutput("postreset finish", {31'd0, finish}, 32'd0);
    @(negedge clk);
    checkOutput("postreset finish2", {31'd0, finish}, 32'd0);

    // A normal job after the reset.
    runJob("afterreset", 4'b1111, 24'd0, 3, 4'b1111, 0, 4'b0, 0, 4'b0,
           0, 5, 4'b1111, 4, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hc_core_scheduler.md
HC_CORE_SCHEDULER -- requirements
Module: hc_core_scheduler

Interface
REQ-001 The module SHALL have parameter NUM_CORES, default 4, number of accelerator cores served (1..16).
REQ-002 The module SHALL have parameter CYCLE_W, default 32, width of the run-cycle counter.
REQ-003 The module SHALL have parameter TIMEOUT_W, default 24, width of the watchdog limit.
REQ-004 The module SHALL have port clk  input  1  single clock for all logic.
REQ-005 The module SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 The module SHALL have port start  input  1  one-cycle job-start pulse from the control block.
REQ-007 The module SHALL have port core_mask  input  NUM_CORES  enabled cores, sampled on the accepted start.
REQ-008 The module SHALL have port timeout_limit  input  TIMEOUT_W  watchdog limit in cycles, sampled on the accepted start.
REQ-009 The module SHALL have port core_finish  input  NUM_CORES  per-core finish pulses or levels.
REQ-010 The module SHALL have port core_start  output  NUM_CORES  per-core one-cycle start pulses.
REQ-011 The module SHALL have port finish  output  1  one-cycle job-complete pulse.
REQ-012 The module SHALL have port busy  output  1  high from LAUNCH through DONE.
REQ-013 The module SHALL have port done_mask  output  NUM_CORES  cores that have finished in the current or last job.
REQ-014 The module SHALL have port timed_out  output  1  sticky flag: last job ended by watchdog.
REQ-015 The module SHALL have port run_cycles  output  CYCLE_W  cycles from LAUNCH to DONE of the last or current job.

Function
REQ-016 The state machine SHALL have states IDLE, LAUNCH, RUN, DONE.
REQ-017 IDLE: start=1 with core_mask!=0 SHALL go to LAUNCH, latch mask/limit, clear done_mask, timed_out and run_cycles.
REQ-018 IDLE: start=1 with core_mask==0 SHALL go directly to DONE (finish pulses on the next cycle, run_cycles=0).
REQ-019 start while not in IDLE SHALL be ignored, with no state or flag change.
REQ-020 LAUNCH SHALL last exactly one cycle, with core_start = latched mask, then go to RUN.
REQ-021 RUN: on each cycle done_mask SHALL OR in core_finish & latched mask; finish from unmasked cores SHALL be ignored.
REQ-022 A core_finish asserted in the LAUNCH cycle SHALL be captured.
REQ-023 RUN SHALL go to DONE on the cycle after done_mask == latched mask; simultaneous finishes from several cores SHALL all count.
REQ-024 run_cycles SHALL increment every cycle in LAUNCH and RUN, saturate at all-ones (no wrap) and hold in DONE/IDLE.
REQ-025 DONE SHALL last exactly one cycle with finish=1, then go to IDLE; busy SHALL drop in IDLE.
REQ-026 Latency from start to core_start SHALL be 1 cycle; from the last core_finish to finish SHALL be 2 cycles.

Reset
REQ-027 reset_n low SHALL asynchronously force IDLE, with core_start=0, finish=0, busy=0, done_mask=0, timed_out=0, run_cycles=0, latched mask/limit=0.
REQ-028 Reset asserted mid-job SHALL abandon the job without a finish pulse; core_finish arriving after release SHALL be ignored in IDLE.
REQ-029 Release of reset SHALL be synchronous in effect: first possible state change on the first clk edge with reset_n high.

Configuration
REQ-030 With HC_SCHED_WATCHDOG_EN defined, a watchdog counter SHALL clear at LAUNCH and count in RUN.
REQ-031 With HC_SCHED_WATCHDOG_EN defined, if the watchdog reaches a nonzero timeout_limit before completion, the FSM SHALL go to DONE with timed_out=1 and done_mask holding the partial result; limit 0 SHALL disable the watchdog.
REQ-032 With HC_SCHED_WATCHDOG_EN defined, completion and timeout in the same cycle SHALL be treated as completion (timed_out=0).
REQ-033 Without HC_SCHED_WATCHDOG_EN, no watchdog logic SHALL exist, timeout_limit SHALL be unused, and timed_out SHALL be tied 0.

Verification
REQ-034 NUM_CORES=4, mask=4'b1010, start; cores 1 and 3 finish at +5 and +9 -> core_start=1010 at +1, finish at +11, done_mask=1010, run_cycles=10.
REQ-035 mask=4'b1111, all core_finish in the same cycle +3 -> finish at +5, done_mask=1111.
REQ-036 mask=0, start -> no core_start, finish one cycle after IDLE exit, run_cycles=0.
REQ-037 Second start during RUN plus core_finish from an unmasked core -> both ignored, done_mask unchanged.
REQ-038 Watchdog build, mask=4'b0011, limit=20, only core 0 finishes -> finish after 20 RUN cycles, timed_out=1, done_mask=0001.
REQ-039 reset_n pulsed low mid-RUN -> all outputs 0 immediately, no finish; a new start afterwards runs normally.
